// File: rtl/char_feeder_pkg.sv
// Shared constants for the keyboard feeder ahead of the 5-character recognizer.
package char_feeder_pkg;

  localparam int CHAR_W = 7;

  localparam logic [CHAR_W-1:0] ASCII_LF = 7'h0A;
  localparam logic [CHAR_W-1:0] ASCII_CR = 7'h0D;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == '1) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// DEPTH x CHAR_W circular buffer; full/empty derived from the occupancy count.
module char_fifo
  import char_feeder_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [CHAR_W-1:0]        wdata,
  input  logic                     pop,
  output logic [CHAR_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [CHAR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/char_feeder.sv
// Buffers typed characters, strips ENTER/CR, and strobes them out at a paced rate,
// flagging end-of-word with the delivered length once the buffer has drained.
module char_feeder
  import char_feeder_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter int                CHAR_W    = 7,
  parameter logic [CHAR_W-1:0] TERM_CHAR = 7'h0A,
  parameter bit                DROP_CR   = 1'b1,
  parameter int                PACE      = 2,
  parameter int                LEN_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CHAR_W-1:0]      in_char,
  output logic                   in_ready,
  output logic [CHAR_W-1:0]      out_char,
  output logic                   out_stb,
  output logic                   word_end,
  output logic [LEN_W-1:0]       word_len,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int PACE_W = $clog2(PACE) + 1;

  logic [1:0]        state_q, state_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CHAR_W-1:0] out_char_q, out_char_d;
  logic              out_stb_q, out_stb_d;
  logic              word_end_q, word_end_d;
  logic [LEN_W-1:0]  word_len_q, word_len_d;

  logic              fifo_full, fifo_empty;
  logic [CHAR_W-1:0] fifo_head;
  logic              accept, is_term, is_cr, push, pop;

  assign in_ready = (state_q == ST_ACCEPT) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign is_term  = (in_char == TERM_CHAR);
  assign is_cr    = DROP_CR && (in_char == CHAR_W'(ASCII_CR));
  assign push     = accept && !is_term && !is_cr;
  assign pop      = !fifo_empty && (pace_q == '0);

  char_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_char),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: if (accept && is_term) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && (pace_q == '0)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_ACCEPT;
      default:   state_d = ST_ACCEPT;
    endcase
  end

  always_comb begin
    pace_d     = pace_q;
    len_d      = len_q;
    out_char_d = out_char_q;
    out_stb_d  = 1'b0;
    word_end_d = 1'b0;
    word_len_d = word_len_q;
    if (pop) begin
      out_char_d = fifo_head;
      out_stb_d  = 1'b1;
      pace_d     = PACE_W'(PACE - 1);
      len_d      = (len_q == '1) ? len_q : len_q + LEN_W'(1);
    end else if (pace_q != '0) begin
      pace_d = pace_q - PACE_W'(1);
    end
    // DONE is only reached with the FIFO empty, so no pop can race the length clear.
    if (state_q == ST_DONE) begin
      word_end_d = 1'b1;
      word_len_d = len_q;
      len_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACCEPT;
      pace_q     <= '0;
      len_q      <= '0;
      out_char_q <= '0;
      out_stb_q  <= 1'b0;
      word_end_q <= 1'b0;
      word_len_q <= '0;
    end else begin
      state_q    <= state_d;
      pace_q     <= pace_d;
      len_q      <= len_d;
      out_char_q <= out_char_d;
      out_stb_q  <= out_stb_d;
      word_end_q <= word_end_d;
      word_len_q <= word_len_d;
    end
  end

  assign out_char = out_char_q;
  assign out_stb  = out_stb_q;
  assign word_end = word_end_q;
  assign word_len = word_len_q;

endmodule

// File: tb/tb_char_feeder.sv
// Directed bench for char_feeder: two instances differing only in CR handling.
module tb_char_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_char = '0;

  logic       in_ready, out_stb, word_end;
  logic [6:0] out_char;
  logic [3:0] word_len;
  logic [3:0] fifo_cnt;

  logic       in_ready2, out_stb2, word_end2;
  logic [6:0] out_char2;
  logic [3:0] word_len2;
  logic [3:0] fifo_cnt2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [6:0] stb_q[$];
  int         stb_c[$];
  logic [6:0] stb2_q[$];
  int         we_cnt, we_cyc, we2_cnt;
  logic [3:0] we_len, we2_len;
  int         max_cnt;
  bit         saw_full_block;
  int         acc_cnt_log[$];
  int         acc_cyc;

  char_feeder #(.DEPTH(8), .CHAR_W(7), .TERM_CHAR(7'h0A), .DROP_CR(1'b1), .PACE(2), .LEN_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_char(out_char), .out_stb(out_stb), .word_end(word_end), .word_len(word_len),
    .fifo_cnt(fifo_cnt)
  );

  char_feeder #(.DEPTH(8), .CHAR_W(7), .TERM_CHAR(7'h0A), .DROP_CR(1'b0), .PACE(2), .LEN_W(4)) u_nocr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready2),
    .out_char(out_char2), .out_stb(out_stb2), .word_end(word_end2), .word_len(word_len2),
    .fifo_cnt(fifo_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    stb_q.delete(); stb_c.delete(); stb2_q.delete(); acc_cnt_log.delete();
    we_cnt = 0; we_cyc = 0; we2_cnt = 0; we_len = '0; we2_len = '0;
    max_cnt = 0; saw_full_block = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_stb) begin stb_q.push_back(out_char); stb_c.push_back(cyc); end
    if (out_stb2) stb2_q.push_back(out_char2);
    if (word_end) begin we_cnt++; we_cyc = cyc; we_len = word_len; end
    if (word_end2) begin we2_cnt++; we2_len = word_len2; end
    if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
    if (fifo_cnt == 4'd8 && !in_ready) saw_full_block = 1'b1;
  endtask

  task automatic send(input logic [6:0] ch);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_char = ch;
    while (!done && n < 50) begin
      done = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    acc_cyc = cyc;
    acc_cnt_log.push_back(int'(fifo_cnt));
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_word(input string tag, input bit both);
    int n;
    n = 0;
    while ((we_cnt == 0 || (both && we2_cnt == 0)) && n < 80) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, "_word_end_count"}, 32'(we_cnt), 32'd1);
  endtask

  task automatic check_strobes(input string tag, input string exp_s);
    byte b;
    check({tag, "_stb_count"}, 32'(stb_q.size()), 32'(exp_s.len()));
    for (int i = 0; i < exp_s.len(); i++) begin
      b = exp_s[i];
      check($sformatf("%s_char%0d", tag, i),
            (i < stb_q.size()) ? 32'(stb_q[i]) : 32'hFFFF_FFFF, 32'(b[6:0]));
    end
    for (int i = 1; i < stb_c.size(); i++) begin
      check($sformatf("%s_gap%0d", tag, i), 32'(stb_c[i] - stb_c[i-1]), 32'd2);
    end
  endtask

  task automatic type_word(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send(b[6:0]);
    end
    send(7'h0A);
  endtask

  initial begin
    string hosse;
    string alpha;
    hosse = "Hosse";
    alpha = "abcdefghijklmnopqrst";

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_out_char", 32'(out_char), 32'd0);
    check("rst_out_stb",  32'(out_stb),  32'd0);
    check("rst_word_end", 32'(word_end), 32'd0);
    check("rst_word_len", 32'(word_len), 32'd0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // "Hosse\n" one character per clock
    clear();
    type_word(hosse);
    wait_word("hosse", 1'b0);
    check_strobes("hosse", hosse);
    check("hosse_len", 32'(we_len), 32'd5);

    // 20 back-to-back characters: fills the FIFO, wraps pointers, saturates length
    clear();
    type_word(alpha);
    wait_word("burst", 1'b0);
    check_strobes("burst", alpha);
    check("burst_len_sat", 32'(we_len), 32'd15);
    check("burst_max_cnt", 32'(max_cnt), 32'd8);
    check("burst_full_blocks", 32'(saw_full_block), 32'd1);
    check("burst_cnt_acc7", 32'(acc_cnt_log[6]), 32'd4);
    check("burst_cnt_acc8_pushpop", 32'(acc_cnt_log[7]), 32'd4);

    // "ab\r\n": CR dropped on u_dut, kept on u_nocr
    clear();
    type_word("ab\r");
    wait_word("cr", 1'b1);
    check_strobes("cr_drop", "ab");
    check("cr_drop_len", 32'(we_len), 32'd2);
    check("nocr_stb_count", 32'(stb2_q.size()), 32'd3);
    check("nocr_char2", (stb2_q.size() > 2) ? 32'(stb2_q[2]) : 32'hFFFF_FFFF, 32'h0D);
    check("nocr_word_end_count", 32'(we2_cnt), 32'd1);
    check("nocr_len", 32'(we2_len), 32'd3);

    // Lone "\n" with an empty FIFO
    clear();
    send(7'h0A);
    check("empty_in_ready_drain", 32'(in_ready), 32'd0);
    tick();
    check("empty_no_early_end", 32'(word_end), 32'd0);
    tick();
    check("empty_word_end", 32'(word_end), 32'd1);
    check("empty_word_len", 32'(word_len), 32'd0);
    check("empty_in_ready_back", 32'(in_ready), 32'd1);
    check("empty_end_delay", 32'(cyc - acc_cyc), 32'd2);
    repeat (3) tick();
    check("empty_no_strobe", 32'(stb_q.size()), 32'd0);

    // Reset while three characters are buffered in DRAIN
    clear();
    type_word("abcdef");
    check("mid_cnt_before_rst", 32'(fifo_cnt), 32'd3);
    check("mid_in_ready_drain", 32'(in_ready), 32'd0);
    check("mid_out_char_before", 32'(out_char), 32'h63);
    clear();
    rst = 1'b1;
    #1;
    check("mid_rst_out_char", 32'(out_char), 32'd0);
    check("mid_rst_out_stb",  32'(out_stb),  32'd0);
    check("mid_rst_word_end", 32'(word_end), 32'd0);
    check("mid_rst_word_len", 32'(word_len), 32'd0);
    check("mid_rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    repeat (6) tick();
    check("mid_no_word_end", 32'(we_cnt), 32'd0);
    check("mid_no_strobe", 32'(stb_q.size()), 32'd0);
    clear();
    type_word(hosse);
    wait_word("rehosse", 1'b0);
    check_strobes("rehosse", hosse);
    check("rehosse_len", 32'(we_len), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
